barrett_batch_ctrl: RTL

Sequencer that streams a batch of N coefficients from a single-port coefficient RAM through the pipelined Barrett reducer and writes each reduced value back to the address it came from.
- Issues one read per cycle; RAM read latency is 1 cycle.
- Feeds the reducer back-to-back and counts returning results; the reducer returns results in order.
- Signals done or error to the polynomial-level controller above it.

---
 rtl/barrett_ctrl_pkg.sv | 7 +
 rtl/params_pkg.sv | 6 +
 rtl/barrett_batch_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/barrett_ctrl_pkg.sv
// State encoding and timeout sizing for the Barrett batch sequencer.
package barrett_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} batch_state_t;

   // Idle cycles tolerated beyond the reducer latency before declaring it stuck.
   localparam int TIMEOUT_MARGIN = 2;
endpackage

// File: rtl/params_pkg.sv
// Shared datapath parameters for the polynomial arithmetic blocks.
package params_pkg;
   localparam int DATA_LENGTH          = 64;
   localparam int BARRETT_PIPE_LATENCY = 4;
   localparam int COEF_ADDR_W          = 8;
endpackage

// File: rtl/barrett_batch_ctrl.sv
// Streams a batch of coefficients from RAM through the Barrett reducer and
// writes every reduced value back to the address it was read from.
module barrett_batch_ctrl
   import barrett_ctrl_pkg::*;
#(
   parameter int DATA_LENGTH = params_pkg::DATA_LENGTH,
   parameter int ADDR_W      = params_pkg::COEF_ADDR_W,
   parameter int PIPE_LAT    = params_pkg::BARRETT_PIPE_LATENCY,
   parameter int TIMEOUT     = PIPE_LAT + TIMEOUT_MARGIN
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [ADDR_W:0]        len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   rd_en_o,
   output logic [ADDR_W-1:0]      rd_addr_o,
   input  logic [DATA_LENGTH-1:0] rd_data_i,
   output logic [DATA_LENGTH-1:0] red_x_o,
   output logic                   red_start_o,
   input  logic [DATA_LENGTH-1:0] red_result_i,
   input  logic                   red_valid_i,
   output logic                   wr_en_o,
   output logic [ADDR_W-1:0]      wr_addr_o,
   output logic [DATA_LENGTH-1:0] wr_data_o
);
   localparam int              IDLE_W  = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

   batch_state_t      state;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   rd_cnt;
   logic [ADDR_W:0]   wr_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              in_batch;
   logic              wr_take;
   logic              wr_last;
   logic              overrun;

   // RAM data goes straight to the reducer; red_start_o marks the cycle it is valid.
   assign red_x_o  = rd_data_i;
   assign in_batch = (state == ISSUE) || (state == DRAIN);
   assign wr_take  = in_batch && red_valid_i && (wr_cnt != len_q);
   assign wr_last  = wr_take && (wr_cnt == len_q - CNT_ONE);
   assign overrun  = in_batch && red_valid_i && (wr_cnt == len_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         len_q       <= '0;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
         idle_cnt    <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         rd_en_o     <= 1'b0;
         rd_addr_o   <= '0;
         red_start_o <= 1'b0;
         wr_en_o     <= 1'b0;
         wr_addr_o   <= '0;
         wr_data_o   <= '0;
      end else begin
         rd_en_o     <= 1'b0;
         wr_en_o     <= 1'b0;
         done_o      <= 1'b0;
         red_start_o <= rd_en_o;

         if (wr_take) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= wr_cnt[ADDR_W-1:0];
            wr_data_o <= red_result_i;
            wr_cnt    <= wr_cnt + CNT_ONE;
         end
         if (overrun) begin
            err_o <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (red_valid_i) begin
                  err_o <= 1'b1;
               end
               // The first read is launched on the accept edge so data arrives in cycle 2.
               if (start_i) begin
                  err_o    <= 1'b0;
                  busy_o   <= 1'b1;
                  len_q    <= len_i;
                  wr_cnt   <= '0;
                  idle_cnt <= '0;
                  if (len_i != '0) begin
                     state     <= ISSUE;
                     rd_en_o   <= 1'b1;
                     rd_addr_o <= '0;
                     rd_cnt    <= CNT_ONE;
                  end else begin
                     state  <= FIN;
                     rd_cnt <= '0;
                  end
               end
            end
            ISSUE: begin
               if (rd_cnt == len_q) begin
                  state <= DRAIN;
               end else begin
                  rd_en_o   <= 1'b1;
                  rd_addr_o <= rd_cnt[ADDR_W-1:0];
                  rd_cnt    <= rd_cnt + CNT_ONE;
               end
            end
            DRAIN: begin
               if (wr_last || (wr_cnt == len_q)) begin
                  state <= FIN;
               end else if (red_valid_i) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                  err_o <= 1'b1;
                  state <= FIN;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            FIN: begin
               if (red_valid_i) begin
                  err_o <= 1'b1;
               end
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
